// File: rtl/pic_intr_sequencer.sv
`default_nettype none
// ============================================================================
// pic_intr_sequencer : 8-level priority interrupt controller, two-pulse INTA
// ============================================================================
module pic_intr_sequencer #(
   parameter bit AEOI = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir,
   input  logic       inta_n,
   input  logic       imr_wr,
   input  logic [7:0] imr_din,
   input  logic       base_wr,
   input  logic [7:0] base_din,
   input  logic       eoi,
   output logic       int_o,
   output logic [7:0] vec_out,
   output logic       vec_oe,
   output logic [7:0] irr,
   output logic [7:0] isr,
   output logic [7:0] imr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT2 = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic       inta_q, inta_d;
   logic [7:0] irr_q, irr_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] imr_q, imr_d;
   logic [4:0] base_q, base_d;
   logic [2:0] lvl_q, lvl_d;
   logic       spur_q, spur_d;
   logic       int_o_q, int_o_d;
   logic [7:0] vec_out_q, vec_out_d;
   logic       vec_oe_q, vec_oe_d;

   // Returns {found, index of lowest set bit}; bit 0 is the highest priority.
   function automatic logic [3:0] lowest(input logic [7:0] v);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = {1'b1, i[2:0]};
      end
      return r;
   endfunction

   logic [7:0] ir_rise;
   logic       ack_fall;
   logic [3:0] cand;
   logic [3:0] isr_lo;
   logic       cand_valid;

   assign ir_rise    = ir & ~ir_q;
   assign ack_fall   = inta_q & ~inta_n;
   assign cand       = lowest(irr_q & ~imr_q);
   assign isr_lo     = lowest(isr_q);
   assign cand_valid = cand[3] && (!isr_lo[3] || (cand[2:0] < isr_lo[2:0]));

   always_comb begin
      state_d   = state_q;
      ir_d      = ir;
      inta_d    = inta_n;
      irr_d     = irr_q;
      isr_d     = isr_q;
      imr_d     = imr_q;
      base_d    = base_q;
      lvl_d     = lvl_q;
      spur_d    = spur_q;
      int_o_d   = 1'b0;
      vec_out_d = vec_out_q;
      vec_oe_d  = vec_oe_q;

      if (imr_wr)  imr_d  = imr_din;
      if (base_wr) base_d = base_din[7:3];

      // EOI acts on the pre-cycle ISR so it composes with an ACK1 set below.
      if (eoi && isr_lo[3]) isr_d[isr_lo[2:0]] = 1'b0;

      case (state_q)
         IDLE: begin
            int_o_d   = cand_valid;
            vec_out_d = 8'h00;
            vec_oe_d  = 1'b0;
            if (ack_fall) begin
               state_d = WAIT2;
               int_o_d = 1'b0;
               if (cand_valid) begin
                  lvl_d              = cand[2:0];
                  spur_d             = 1'b0;
                  isr_d[cand[2:0]]   = 1'b1;
                  irr_d[cand[2:0]]   = 1'b0;
               end else begin
                  lvl_d  = 3'd7;
                  spur_d = 1'b1;
               end
            end
         end
         WAIT2: begin
            if (ack_fall) begin
               state_d   = DRIVE;
               vec_out_d = {base_q, lvl_q};
               vec_oe_d  = 1'b1;
            end
         end
         DRIVE: begin
            if (inta_n) begin
               state_d   = IDLE;
               vec_out_d = 8'h00;
               vec_oe_d  = 1'b0;
               if (AEOI && !spur_q) isr_d[lvl_q] = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            vec_out_d = 8'h00;
            vec_oe_d  = 1'b0;
         end
      endcase

      // A new edge wins over the ACK1 clear of the same bit.
      irr_d = irr_d | ir_rise;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ir_q      <= 8'hFF;
         inta_q    <= 1'b1;
         irr_q     <= 8'h00;
         isr_q     <= 8'h00;
         imr_q     <= 8'hFF;
         base_q    <= 5'd0;
         lvl_q     <= 3'd0;
         spur_q    <= 1'b0;
         int_o_q   <= 1'b0;
         vec_out_q <= 8'h00;
         vec_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         inta_q    <= inta_d;
         irr_q     <= irr_d;
         isr_q     <= isr_d;
         imr_q     <= imr_d;
         base_q    <= base_d;
         lvl_q     <= lvl_d;
         spur_q    <= spur_d;
         int_o_q   <= int_o_d;
         vec_out_q <= vec_out_d;
         vec_oe_q  <= vec_oe_d;
      end
   end

   assign int_o   = int_o_q;
   assign vec_out = vec_out_q;
   assign vec_oe  = vec_oe_q;
   assign irr     = irr_q;
   assign isr     = isr_q;
   assign imr     = imr_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_intr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pic_intr_sequencer : directed checks, explicit-EOI and AEOI instances
// ============================================================================
module tb_pic_intr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ir;
   logic       inta_n;
   logic       imr_wr;
   logic [7:0] imr_din;
   logic       base_wr;
   logic [7:0] base_din;
   logic       eoi;

   logic       int_o, int_o_a;
   logic [7:0] vec_out, vec_out_a;
   logic       vec_oe, vec_oe_a;
   logic [7:0] irr, irr_a, isr, isr_a, imr, imr_a;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] v, v_a, isr_a_mid;
   logic       oe, oe_a;

   always #5 clk = ~clk;

   pic_intr_sequencer #(.AEOI(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .inta_n(inta_n),
      .imr_wr(imr_wr), .imr_din(imr_din), .base_wr(base_wr), .base_din(base_din),
      .eoi(eoi), .int_o(int_o), .vec_out(vec_out), .vec_oe(vec_oe),
      .irr(irr), .isr(isr), .imr(imr)
   );

   pic_intr_sequencer #(.AEOI(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ir(ir), .inta_n(inta_n),
      .imr_wr(imr_wr), .imr_din(imr_din), .base_wr(base_wr), .base_din(base_din),
      .eoi(eoi), .int_o(int_o_a), .vec_out(vec_out_a), .vec_oe(vec_oe_a),
      .irr(irr_a), .isr(isr_a), .imr(imr_a)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wr_base(input logic [7:0] d);
      base_wr = 1'b1; base_din = d; tick(); base_wr = 1'b0;
   endtask

   task automatic wr_imr(input logic [7:0] d);
      imr_wr = 1'b1; imr_din = d; tick(); imr_wr = 1'b0;
   endtask

   task automatic pulse_ir(input logic [7:0] m);
      ir = ir | m;  tick();
      ir = ir & ~m; tick();
   endtask

   task automatic pulse_eoi;
      eoi = 1'b1; tick(); eoi = 1'b0;
   endtask

   // Full two-pulse acknowledge; vectors captured while in DRIVE.
   task automatic intack;
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      v = vec_out; oe = vec_oe; v_a = vec_out_a; oe_a = vec_oe_a; isr_a_mid = isr_a;
      inta_n = 1'b1; tick();
   endtask

   initial begin
      rst_n = 1'b1; ir = 8'h00; inta_n = 1'b1; imr_wr = 1'b0; imr_din = 8'h00;
      base_wr = 1'b0; base_din = 8'h00; eoi = 1'b0;
      #2;
      do_reset();
      check("rst_irr", irr, 8'h00);
      check("rst_isr", isr, 8'h00);
      check("rst_imr", imr, 8'hFF);
      check("rst_int", int_o, 1'b0);
      check("rst_oe", vec_oe, 1'b0);
      check("rst_vec", vec_out, 8'h00);

      // Basic single request
      wr_base(8'h40);
      wr_imr(8'h00);
      pulse_ir(8'h08);
      check("basic_int", int_o, 1'b1);
      check("basic_irr_pend", irr, 8'h08);
      intack();
      check("basic_vec", v, 8'h43);
      check("basic_oe", oe, 1'b1);
      check("basic_isr", isr, 8'h08);
      check("basic_irr", irr, 8'h00);
      check("basic_oe_off", vec_oe, 1'b0);
      check("basic_vec_off", vec_out, 8'h00);
      pulse_eoi();
      check("eoi_clr", isr, 8'h00);
      pulse_eoi();
      check("eoi_empty", isr, 8'h00);

      // Priority: ir5 and ir2 simultaneously
      pulse_ir(8'h24);
      check("prio_irr", irr, 8'h24);
      check("prio_int", int_o, 1'b1);
      intack();
      check("prio_vec1", v, 8'h42);
      check("prio_isr1", isr, 8'h04);
      check("prio_irr1", irr, 8'h20);
      check("prio_int_blk", int_o, 1'b0);
      pulse_eoi();
      tick();
      check("prio_int2", int_o, 1'b1);
      intack();
      check("prio_vec2", v, 8'h45);
      check("prio_isr2", isr, 8'h20);
      pulse_eoi();

      // Nesting
      pulse_ir(8'h08);
      intack();
      check("nest_isr0", isr, 8'h08);
      pulse_ir(8'h40);
      tick();
      check("nest_low_blk", int_o, 1'b0);
      pulse_ir(8'h02);
      check("nest_high_int", int_o, 1'b1);
      intack();
      check("nest_vec", v, 8'h41);
      check("nest_isr", isr, 8'h0A);
      check("nest_irr", irr, 8'h40);
      pulse_eoi();
      check("nest_eoi", isr, 8'h08);

      // Spurious: request masked between int_o and ACK1
      do_reset();
      wr_base(8'h80);
      wr_imr(8'h00);
      pulse_ir(8'h10);
      check("spur_int", int_o, 1'b1);
      wr_imr(8'h10);
      check("spur_imr", imr, 8'h10);
      intack();
      check("spur_vec", v, 8'h87);
      check("spur_oe", oe, 1'b1);
      check("spur_isr", isr, 8'h00);
      check("spur_irr", irr, 8'h10);
      check("spur_int_off", int_o, 1'b0);

      // AEOI instance against the explicit-EOI instance
      do_reset();
      wr_base(8'h40);
      wr_imr(8'h00);
      pulse_ir(8'h01);
      check("aeoi_int", int_o_a, 1'b1);
      intack();
      check("aeoi_vec", v_a, 8'h40);
      check("aeoi_isr_mid", isr_a_mid, 8'h01);
      check("aeoi_isr_end", isr_a, 8'h00);
      check("noaeoi_isr_end", isr, 8'h01);

      // Reset while in DRIVE, with ir held high across reset release
      pulse_eoi();
      ir = 8'h04; tick(); tick();
      check("rdrv_int", int_o, 1'b1);
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      check("rdrv_oe_on", vec_oe, 1'b1);
      check("rdrv_vec_on", vec_out, 8'h42);
      rst_n = 1'b0; inta_n = 1'b1; tick(); rst_n = 1'b1;
      check("rdrv_oe", vec_oe, 1'b0);
      check("rdrv_isr", isr, 8'h00);
      check("rdrv_imr", imr, 8'hFF);
      wr_imr(8'h00);
      tick(); tick(); tick();
      check("rdrv_int_held", int_o, 1'b0);
      check("rdrv_irr_held", irr, 8'h00);
      ir = 8'h00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pic_intr_sequencer.md
PIC_INTR_SEQUENCER -- requirements
Module: pic_intr_sequencer

Interface
REQ-001 Parameter AEOI, default 0, meaning: 1 = automatic end-of-interrupt (ISR bit cleared at end of acknowledge), 0 = explicit EOI required.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ir  input  8  interrupt request lines, edge-triggered; IR0 highest, IR7 lowest priority.
REQ-005 inta_n  input  1  CPU interrupt acknowledge, active-low, synchronous to clk.
REQ-006 imr_wr / imr_din  input  1 / 8  mask register write strobe and data.
REQ-007 base_wr / base_din  input  1 / 8  vector base write strobe and data; only bits [7:3] stored.
REQ-008 eoi  input  1  one-cycle non-specific end-of-interrupt pulse.
REQ-009 int_o  output  1  interrupt request to CPU, registered.
REQ-010 vec_out / vec_oe  output  8 / 1  interrupt vector and its drive-enable.
REQ-011 irr / isr / imr  output  8 each  request, in-service, mask register status.

Function
REQ-012 ir_q and inta_q shall register ir and inta_n each cycle; a rising edge is ir & ~ir_q, an INTA falling edge is inta_q & ~inta_n.
REQ-013 IRR[i] shall set on a rising edge of ir[i] and clear when selected at ACK1; set shall win over clear in the same cycle.
REQ-014 Masking shall gate only selection and int_o; IRR bits shall not be cleared by IMR; IMR and base writes take effect the cycle after the strobe.
REQ-015 Candidate = lowest-index bit of IRR & ~IMR; it shall be valid only if its index is strictly lower than the lowest set ISR index (ISR empty = always valid).
REQ-016 FSM states: IDLE, WAIT2, DRIVE.
REQ-017 IDLE: int_o shall be 1 the cycle after a valid candidate exists and 0 otherwise; an INTA falling edge (ACK1) shall move to WAIT2.
REQ-018 At ACK1 the valid candidate index shall be latched as lvl, ISR[lvl] set, IRR[lvl] cleared, int_o forced 0 next cycle.
REQ-019 At ACK1 with no valid candidate (request masked or withdrawn), lvl shall be 7 (spurious), ISR and IRR unchanged.
REQ-020 WAIT2: int_o held 0; the next INTA falling edge (ACK2) shall move to DRIVE.
REQ-021 DRIVE: vec_out = {base[7:3], lvl[2:0]} and vec_oe = 1 from the cycle after ACK2 until the cycle after inta_n returns high, then IDLE with vec_oe = 0 and vec_out = 0.
REQ-022 AEOI = 1: on leaving DRIVE, ISR[lvl] shall clear (not for spurious).
REQ-023 eoi shall clear the lowest-index set ISR bit of the pre-cycle ISR; eoi with ISR = 0 has no effect; eoi coincident with ACK1 shall apply both updates.
REQ-024 eoi in WAIT2/DRIVE shall act on ISR without changing FSM state.
REQ-025 inta_n falling edges outside IDLE/WAIT2 transitions (e.g. in DRIVE) shall be ignored.
REQ-026 Nesting: a new valid candidate while ISR is non-zero shall re-assert int_o only when the FSM is in IDLE.

Reset
REQ-027 rst_n low at a clock edge shall force: IRR = 0, ISR = 0, IMR = 8'hFF, base = 0, lvl = 0, state = IDLE, int_o = 0, vec_out = 0, vec_oe = 0, ir_q = 8'hFF, inta_q = 1.
REQ-028 Reset in any state (including WAIT2/DRIVE) shall take effect at that edge; a level held high on ir across reset release shall not create a request.

Verification
REQ-029 Basic: base_wr 8'h40, imr 8'h00, pulse ir[3] -> int_o = 1; two INTA pulses -> vec_out = 8'h43 with vec_oe, ISR = 8'h08, IRR = 0.
REQ-030 Priority: rising ir[5] and ir[2] same cycle -> first cycle vector 8'h42; after eoi, second cycle vector 8'h45.
REQ-031 Nesting: ISR = 8'h08 in service, ir[6] rises -> int_o stays 0; ir[1] rises -> int_o = 1, ack yields ISR = 8'h0A; eoi -> ISR = 8'h08.
REQ-032 Spurious: ir[4] requested, int_o = 1, imr_wr 8'h10 before ACK1 -> vector {base,3'd7}, ISR unchanged, IRR[4] still 1.
REQ-033 AEOI = 1: single ir[0] cycle -> ISR = 0 after inta_n returns high, no eoi needed.
REQ-034 Reset in DRIVE: rst_n low one cycle -> vec_oe = 0, ISR = 0, IMR = 8'hFF next cycle; ir held high gives no int_o.
